// File: rtl/mysystem_pio_poller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mysystem_pio_poller_pkg
// Purpose  : Shared FSM state type and width helpers for the PIO poller.
// Revision : 1.0 - initial release
// ============================================================================
package mysystem_pio_poller_pkg;

  // Poller transaction phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    EVAL = 2'd3
  } state_t;

  // Width of the poll timer: must reach PERIOD-1.
  function automatic int timer_width(input int period);
    return (period < 2) ? 1 : $clog2(period);
  endfunction

  // Width of the debounce match counter: must reach N.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage : mysystem_pio_poller_pkg
`default_nettype wire

// File: rtl/mysystem_pio_poller_if.sv
`default_nettype none
// ============================================================================
// Module   : mysystem_pio_poller_if
// Purpose  : Avalon-MM read-only bus between the poller (master) and the PIO
//            slave.
// Revision : 1.0 - initial release
// ============================================================================
interface mysystem_pio_poller_if #(
  parameter int ADDR_W = 2
) ();

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );

endinterface : mysystem_pio_poller_if
`default_nettype wire

// File: rtl/mysystem_poll_timer.sv
`default_nettype none
// ============================================================================
// Module   : mysystem_poll_timer
// Purpose  : Saturating period counter with count enable, synchronous clear
//            and a terminal-count flag at PERIOD-1.
// Revision : 1.0 - initial release
// ============================================================================
module mysystem_poll_timer #(
  parameter int PERIOD = 50000,
  parameter int W      = 16
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  i_en,
  input  wire  i_clr,
  output logic o_tc
);

  logic [W-1:0] r_count;
  logic         w_tc;

  assign w_tc = (r_count == W'(PERIOD - 1));
  assign o_tc = w_tc;

  // Count up while enabled, stop at terminal count; clear has priority.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_tc) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule : mysystem_poll_timer
`default_nettype wire

// File: rtl/mysystem_pio_poller.sv
`default_nettype none
// ============================================================================
// Module   : mysystem_pio_poller
// Purpose  : Avalon-MM read master that periodically polls a PIO slave,
//            debounces the low DATA_W bits and presents a committed value
//            with a change pulse and a level IRQ.
// Options  : PIO_EDGE_CAPTURE_EN - sticky rising-edge flags on edge_rise;
//            undefined means edge_rise is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module mysystem_pio_poller
  import mysystem_pio_poller_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int ADDR_W      = 2,
  parameter int PIO_ADDR    = 0,
  parameter int POLL_PERIOD = 50000,
  parameter int DEBOUNCE_N  = 3
) (
  input  wire                   clk,
  input  wire                   reset,
  input  wire                   enable,
  mysystem_pio_poller_if.master avm,
  output logic [DATA_W-1:0]     value,
  output logic                  value_changed,
  output logic                  irq,
  input  wire                   irq_ack,
  output logic [DATA_W-1:0]     edge_rise
);

  localparam int TW = timer_width(POLL_PERIOD);
  localparam int CW = cnt_width(DEBOUNCE_N);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_capture;
  logic              w_tc;
  logic              w_tmr_en;
  logic              w_tmr_clr;

  logic [DATA_W-1:0] r_sample;
  logic [DATA_W-1:0] r_cand;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_value;
  logic              r_value_changed;
  logic              r_irq;

  logic [CW-1:0]     w_cnt_nxt;
  logic              w_commit;

  // Timer only advances while idle and enabled; it restarts on launch and
  // is held at zero whenever polling is disabled.
  assign w_tmr_en  = (r_state == IDLE) && enable;
  assign w_tmr_clr = !enable || ((r_state == IDLE) && w_tc);

  mysystem_poll_timer #(
    .PERIOD (POLL_PERIOD),
    .W      (TW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_tmr_en),
    .i_clr (w_tmr_clr),
    .o_tc  (w_tc)
  );

  // Address is constant; read is a pure decode of the REQ state so the pair
  // stays stable for the whole stall.
  assign avm.avm_address = ADDR_W'(PIO_ADDR);
  assign avm.avm_read    = (r_state == REQ);

  // Upper readdata bits are deliberately ignored.
  generate
    if (DATA_W < 32) begin : g_rd_unused
      wire w_unused_rdata = ^avm.avm_readdata[31:DATA_W];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and sample-capture decode; zero-latency data skips WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_tc && enable) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (!avm.avm_waitrequest) begin
          if (avm.avm_readdatavalid) begin
            w_capture   = 1'b1;
            w_state_nxt = EVAL;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (avm.avm_readdatavalid) begin
          w_capture   = 1'b1;
          w_state_nxt = EVAL;
        end
      end
      EVAL: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Hold the captured sample for evaluation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample <= '0;
    end else if (w_capture) begin
      r_sample <= avm.avm_readdata[DATA_W-1:0];
    end
  end

  // The new candidate is always the sample; the match count restarts on a
  // change and saturates at DEBOUNCE_N.
  always_comb begin
    w_cnt_nxt = CW'(1);
    if (r_sample == r_cand) begin
      w_cnt_nxt = (r_cnt >= CW'(DEBOUNCE_N)) ? CW'(DEBOUNCE_N) : (r_cnt + CW'(1));
    end
    w_commit = (r_state == EVAL) && (w_cnt_nxt == CW'(DEBOUNCE_N)) && (r_sample != r_value);
  end

  // Debounce state, committed value, change pulse and IRQ (set beats ack).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand          <= '0;
      r_cnt           <= '0;
      r_value         <= '0;
      r_value_changed <= 1'b0;
      r_irq           <= 1'b0;
    end else begin
      r_value_changed <= w_commit;
      if (r_state == EVAL) begin
        r_cand <= r_sample;
        r_cnt  <= w_cnt_nxt;
      end
      if (w_commit) begin
        r_value <= r_sample;
      end
      if (w_commit) begin
        r_irq <= 1'b1;
      end else if (irq_ack) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign value         = r_value;
  assign value_changed = r_value_changed;
  assign irq           = r_irq;

`ifdef PIO_EDGE_CAPTURE_EN
  logic [DATA_W-1:0] r_edge;

  // Sticky rising-edge flags; ack clears, but a bit rising on the same
  // commit survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_edge <= '0;
    end else begin
      r_edge <= (irq_ack ? '0 : r_edge) | (w_commit ? (r_sample & ~r_value) : '0);
    end
  end

  assign edge_rise = r_edge;
`else
  assign edge_rise = '0;
`endif

endmodule : mysystem_pio_poller
`default_nettype wire

// File: tb/tb_mysystem_pio_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mysystem_pio_poller
// Purpose  : Self-checking bench for mysystem_pio_poller with a bench-side
//            Avalon slave and a sample-history reference model.
// Options  : PIO_EDGE_CAPTURE_EN - also checks the sticky edge flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mysystem_pio_poller;

  localparam int DW = 10;
  localparam int AW = 2;
  localparam int PA = 1;
  localparam int PP = 8;
  localparam int DN = 3;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          irq_ack;
  logic [DW-1:0] value;
  logic          value_changed;
  logic          irq;
  logic [DW-1:0] edge_rise;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;

  // Reference model state
  logic [DW-1:0] hist[$];
  logic [DW-1:0] m_value;
  logic          m_irq;
  logic [DW-1:0] m_edge;

  mysystem_pio_poller_if #(.ADDR_W(AW)) u_bus ();

  mysystem_pio_poller #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .PIO_ADDR    (PA),
    .POLL_PERIOD (PP),
    .DEBOUNCE_N  (DN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .avm           (u_bus.master),
    .value         (value),
    .value_changed (value_changed),
    .irq           (irq),
    .irq_ack       (irq_ack),
    .edge_rise     (edge_rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (value_changed === 1'b1) pulse_cnt++;

  function automatic logic [DW-1:0] exp_edge();
`ifdef PIO_EDGE_CAPTURE_EN
    return m_edge;
`else
    return '0;
`endif
  endfunction

  // Model: commit when the last DN samples agree and differ from the value.
  function automatic bit model_sample(input logic [DW-1:0] d, input bit ack);
    bit all_eq;
    bit commit;
    hist.push_back(d);
    if (hist.size() > DN) void'(hist.pop_front());
    all_eq = (hist.size() == DN);
    foreach (hist[i]) if (hist[i] != d) all_eq = 1'b0;
    commit = all_eq && (d != m_value);
    if (ack) begin
      m_irq  = 1'b0;
      m_edge = '0;
    end
    if (commit) begin
      m_edge  = m_edge | (d & ~m_value);
      m_value = d;
      m_irq   = 1'b1;
    end
    return commit;
  endfunction

  // One full read: wait for the request, stall, accept, return data.
  task automatic do_read(input logic [DW-1:0] data, input int stall, input bit zl,
                         input bit ack_eval, input string tag);
    int t;
    bit exp_pulse;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (u_bus.avm_read !== 1'b1 && t < 4 * PP);
    n_checks++;
    if (u_bus.avm_read !== 1'b1) begin
      $display("FAIL %s req_timeout: avm_read=%b required 1", tag, u_bus.avm_read);
      return;
    end else n_pass++;
    n_checks++;
    if (u_bus.avm_address !== AW'(PA))
      $display("FAIL %s address: got %h required %h", tag, u_bus.avm_address, AW'(PA));
    else n_pass++;
    for (int s = 1; s < stall; s++) begin
      @(negedge clk);
      n_checks++;
      if (u_bus.avm_read !== 1'b1 || u_bus.avm_address !== AW'(PA))
        $display("FAIL %s req_hold: read=%b addr=%h required 1/%h", tag,
                 u_bus.avm_read, u_bus.avm_address, AW'(PA));
      else n_pass++;
    end
    u_bus.avm_waitrequest = 1'b0;
    if (zl) begin
      u_bus.avm_readdatavalid = 1'b1;
      u_bus.avm_readdata      = {22'($urandom), data};
    end
    @(negedge clk);
    u_bus.avm_waitrequest = 1'b1;
    if (zl) begin
      u_bus.avm_readdatavalid = 1'b0;
      u_bus.avm_readdata      = 32'($urandom);
    end else begin
      n_checks++;
      if (u_bus.avm_read !== 1'b0)
        $display("FAIL %s single_req: avm_read=%b required 0", tag, u_bus.avm_read);
      else n_pass++;
      u_bus.avm_readdatavalid = 1'b1;
      u_bus.avm_readdata      = {22'($urandom), data};
      @(negedge clk);
      u_bus.avm_readdatavalid = 1'b0;
      u_bus.avm_readdata      = 32'($urandom);
    end
    n_checks++;
    if (u_bus.avm_read !== 1'b0 || value !== m_value)
      $display("FAIL %s eval: read=%b value=%h required 0/%h", tag, u_bus.avm_read, value, m_value);
    else n_pass++;
    if (ack_eval) irq_ack = 1'b1;
    exp_pulse = model_sample(data, ack_eval);
    @(negedge clk);
    irq_ack = 1'b0;
    n_checks++;
    if (value !== m_value || value_changed !== exp_pulse || irq !== m_irq || edge_rise !== exp_edge())
      $display("FAIL %s commit: value=%h chg=%b irq=%b edge=%h required %h/%b/%b/%h", tag,
               value, value_changed, irq, edge_rise, m_value, exp_pulse, m_irq, exp_edge());
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (value_changed !== 1'b0)
      $display("FAIL %s pulse_width: value_changed=%b required 0", tag, value_changed);
    else n_pass++;
  endtask

  task automatic model_reset();
    hist.delete();
    m_value = '0;
    m_irq   = 1'b0;
    m_edge  = '0;
  endtask

  task automatic ack_irq(input string tag);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    m_irq   = 1'b0;
    m_edge  = '0;
    n_checks++;
    if (irq !== 1'b0 || edge_rise !== '0)
      $display("FAIL %s ack: irq=%b edge=%h required 0/0", tag, irq, edge_rise);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    n_checks++;
    if (u_bus.avm_read !== 1'b0 || value !== '0 || value_changed !== 1'b0 || irq !== 1'b0 ||
        edge_rise !== '0)
      $display("FAIL reset_state: read=%b value=%h chg=%b irq=%b edge=%h required all 0",
               u_bus.avm_read, value, value_changed, irq, edge_rise);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_constant();
    int base;
    base = pulse_cnt;
    for (int i = 0; i < 3; i++) do_read(10'h155, 1, 1'b0, 1'b0, "const");
    n_checks++;
    if (pulse_cnt - base != 1 || value !== 10'h155 || irq !== 1'b1)
      $display("FAIL const_result: pulses=%0d value=%h irq=%b required 1/155/1",
               pulse_cnt - base, value, irq);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int base;
    logic [DW-1:0] seq [5];
    seq = '{10'h001, 10'h002, 10'h001, 10'h001, 10'h001};
    ack_irq("bounce_pre");
    base = pulse_cnt;
    foreach (seq[i]) do_read(seq[i], 1, 1'b0, 1'b0, "bounce");
    n_checks++;
    if (pulse_cnt - base != 1 || value !== 10'h001)
      $display("FAIL bounce_result: pulses=%0d value=%h required 1/001", pulse_cnt - base, value);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_read(10'h0F0, 5, 1'b0, 1'b0, "stall");
  endtask

  task automatic test_ack_collision();
    ack_irq("coll_pre");
    do_read(10'h0AA, 1, 1'b0, 1'b0, "coll");
    do_read(10'h0AA, 2, 1'b1, 1'b0, "coll");
    do_read(10'h0AA, 1, 1'b0, 1'b1, "coll_ack");
    ack_irq("coll_post");
  endtask

  task automatic test_reset_in_wait();
    int t;
    int base;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (u_bus.avm_read !== 1'b1 && t < 4 * PP);
    n_checks++;
    if (u_bus.avm_read !== 1'b1)
      $display("FAIL rstwait_timeout: avm_read=%b required 1", u_bus.avm_read);
    else n_pass++;
    u_bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    u_bus.avm_waitrequest = 1'b1;
    reset = 1'b1;
    base = pulse_cnt;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    u_bus.avm_readdatavalid = 1'b1;
    u_bus.avm_readdata      = 32'h0000_03FF;
    @(negedge clk);
    u_bus.avm_readdatavalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (value !== '0 || u_bus.avm_read !== 1'b0 || irq !== 1'b0 || pulse_cnt != base)
      $display("FAIL rstwait_state: value=%h read=%b irq=%b pulses=%0d required 0/0/0/0",
               value, u_bus.avm_read, irq, pulse_cnt - base);
    else n_pass++;
    do_read(10'h3FF, 1, 1'b0, 1'b0, "rstwait_next");
  endtask

  task automatic test_edge();
    for (int i = 0; i < 3; i++) do_read(10'h005, 1, 1'b0, 1'b0, "edge_a");
    for (int i = 0; i < 3; i++) do_read(10'h004, 1, 1'b0, 1'b0, "edge_b");
    n_checks++;
    if (edge_rise !== exp_edge() || value !== 10'h004)
      $display("FAIL edge_sticky: edge=%h value=%h required %h/004", edge_rise, value, exp_edge());
    else n_pass++;
    ack_irq("edge_ack");
  endtask

  task automatic test_enable();
    int seen;
    seen = 0;
    enable = 1'b0;
    for (int i = 0; i < 5 * PP; i++) begin
      @(negedge clk);
      if (u_bus.avm_read === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL enable_off: read cycles=%0d required 0", seen);
    else n_pass++;
    enable = 1'b1;
    do_read(10'h004, 1, 1'b0, 1'b0, "enable_on");
  endtask

  task automatic test_random();
    logic [DW-1:0] pool [4];
    logic [DW-1:0] v;
    int len;
    pool = '{10'h000, 10'h3FF, 10'h155, 10'h2AA};
    for (int r = 0; r < 8; r++) begin
      v   = pool[$urandom_range(0, 3)];
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++)
        do_read(v, $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), "random");
    end
  endtask

  initial begin
    reset                   = 1'b1;
    enable                  = 1'b1;
    irq_ack                 = 1'b0;
    u_bus.avm_waitrequest   = 1'b1;
    u_bus.avm_readdatavalid = 1'b0;
    u_bus.avm_readdata      = '0;
    model_reset();
    test_reset();
    test_constant();
    test_bounce();
    test_stall();
    test_ack_collision();
    test_reset_in_wait();
    test_edge();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_mysystem_pio_poller
`default_nettype wire
